// File: rtl/gpr_bus_pkg.sv
// Shared definitions for the GPR register-file bus master: FSM encoding and
// default bus geometry.
package gpr_bus_pkg;

   // Default bus geometry
   localparam int unsigned GPR_DATA_WIDTH = 16;
   localparam int unsigned GPR_ADDR_WIDTH = 16;

   // Responder register index width (8 general-purpose registers)
   localparam int unsigned GPR_IDX_WIDTH  = 3;

   // Master transaction FSM
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } gpr_state_e;

endpackage : gpr_bus_pkg

// File: rtl/gpr_bus_timeout.sv
// Transaction watchdog: up-counter cleared when a request is accepted,
// counting while enabled, and saturating at TIMEOUT_CYCLES where it flags expiry.
module gpr_bus_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   assign expired_o = (count_q == CNT_WIDTH'(TIMEOUT_CYCLES));

   // Next count: clear wins, otherwise count up until expiry and hold there
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && !expired_o) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values, independent of block evaluation order.
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule : gpr_bus_timeout

// File: rtl/gpr_bus_master.sv
// GPR register-file bus initiator. Takes single read/write requests from a
// valid/ready host port, runs one cs/rdy handshake on the shared tristate bus
// and returns read data or a timeout error as a one-cycle response pulse.
module gpr_bus_master
   import gpr_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = GPR_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH     = GPR_ADDR_WIDTH,
   parameter int unsigned TIMEOUT_CYCLES = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   // Host request port
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   // Host response port
   output logic                  rsp_valid,
   output logic                  rsp_error,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   // GPR bus
   output logic                  bus_cs,
   output logic                  bus_read,
   output logic [ADDR_WIDTH-1:0] bus_address,
   inout  wire  [DATA_WIDTH-1:0] bus_data,
   input  logic                  bus_rdy
);

   gpr_state_e            state_q, state_d;
   logic                  cs_q, cs_d;
   logic                  read_q, read_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_error_q, rsp_error_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

   logic                  accept;
   logic                  expired;

   // A request is taken only when idle and the responder is itself idle
   assign req_ready = (state_q == ST_IDLE) & bus_rdy & ~rst;
   assign accept    = req_valid & req_ready;

   // Watchdog runs from acceptance through ISSUE and WAIT
   gpr_bus_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (accept),
      .enable_i  ((state_q == ST_ISSUE) || (state_q == ST_WAIT)),
      .expired_o (expired)
   );

   // Write data goes on the bus only while selecting the responder for a write
   assign bus_data    = (cs_q && !read_q) ? wdata_q : {DATA_WIDTH{1'bz}};
   assign bus_cs      = cs_q;
   assign bus_read    = read_q;
   assign bus_address = addr_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_error   = rsp_error_q;
   assign rsp_rdata   = rsp_rdata_q;

   // Next-state and registered-output decode; normal progress beats timeout
   always_comb begin
      state_d     = state_q;
      cs_d        = cs_q;
      read_d      = read_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rsp_valid_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_ISSUE;
               cs_d    = 1'b1;
               read_d  = ~req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end
         end

         ST_ISSUE: begin
            if (!bus_rdy) begin
               state_d = ST_WAIT;
            end else if (expired) begin
               state_d     = ST_RESP;
               cs_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         ST_WAIT: begin
            if (bus_rdy) begin
               // cs drops on the same edge that sees rdy so the responder
               // cannot start a second access from its idle state
               state_d     = ST_RESP;
               cs_d        = 1'b0;
               rsp_valid_d = 1'b1;
               if (read_q) begin
                  rsp_rdata_d = bus_data;
               end
            end else if (expired) begin
               state_d     = ST_RESP;
               cs_d        = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_error_d = 1'b1;
               rsp_rdata_d = '0;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
            cs_d    = 1'b0;
         end
      endcase
   end

   // State and bus/response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cs_q        <= 1'b0;
         read_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cs_q        <= cs_d;
         read_q      <= read_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

endmodule : gpr_bus_master
